// File: rtl/load_wb_buffer_pkg.sv
// rtl/load_wb_buffer_pkg.sv - shared widths and ROB age helpers for the load writeback path
package load_wb_buffer_pkg;

    localparam int INSTR_ID_WIDTH = 6;
    localparam int PREG_W         = 6;
    localparam int RESULT_W       = 64;

    typedef logic [INSTR_ID_WIDTH-1:0] robid_t;
    typedef logic [PREG_W-1:0]         preg_t;
    typedef logic [RESULT_W-1:0]       result_t;

    function automatic logic robid_wrap(input robid_t id);
        return id[INSTR_ID_WIDTH-1];
    endfunction

    function automatic logic [INSTR_ID_WIDTH-2:0] robid_idx(input robid_t id);
        return id[INSTR_ID_WIDTH-2:0];
    endfunction

    // a is younger than b; the wrap bit flips each time the ROB index rolls over
    function automatic logic younger(input robid_t a, input robid_t b);
        if (robid_wrap(a) != robid_wrap(b)) begin
            return robid_idx(a) < robid_idx(b);
        end
        return robid_idx(a) > robid_idx(b);
    endfunction

endpackage

// File: rtl/load_wb_buffer_if.sv
// rtl/load_wb_buffer_if.sv - MEM->WB result, flush and writeback port bundle
interface load_wb_buffer_if;
    import load_wb_buffer_pkg::*;

    logic    memwb_instr_valid;
    robid_t  memwb_robid;
    preg_t   memwb_prd;
    logic    memwb_need_to_wb;
    logic    memwb_mmio_valid;
    result_t memwb_opload_rddata;

    logic    flush_valid;
    robid_t  flush_robid;

    logic    mem_stall;

    logic    wb_valid;
    logic    wb_ready;
    robid_t  wb_robid;
    preg_t   wb_prd;
    logic    wb_need_to_wb;
    logic    wb_mmio_valid;
    result_t wb_rddata;

    modport master (
        output memwb_instr_valid, memwb_robid, memwb_prd, memwb_need_to_wb,
               memwb_mmio_valid, memwb_opload_rddata,
               flush_valid, flush_robid, wb_ready,
        input  mem_stall, wb_valid, wb_robid, wb_prd, wb_need_to_wb,
               wb_mmio_valid, wb_rddata
    );

    modport slave (
        input  memwb_instr_valid, memwb_robid, memwb_prd, memwb_need_to_wb,
               memwb_mmio_valid, memwb_opload_rddata,
               flush_valid, flush_robid, wb_ready,
        output mem_stall, wb_valid, wb_robid, wb_prd, wb_need_to_wb,
               wb_mmio_valid, wb_rddata
    );

endinterface

// File: rtl/load_wb_buffer.sv
// rtl/load_wb_buffer.sv - circular buffer between the MEM->WB register and the writeback port
module load_wb_buffer
    import load_wb_buffer_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int ID_W  = INSTR_ID_WIDTH
) (
    input  logic            clock,
    input  logic            reset_n,
    load_wb_buffer_if.slave bus
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_STALL = CNT_W'(DEPTH - 1);

    logic [DEPTH-1:0] vld_q;
    logic [ID_W-1:0]  robid_q [DEPTH];
    preg_t            prd_q   [DEPTH];
    logic [DEPTH-1:0] need_q;
    logic [DEPTH-1:0] mmio_q;
    result_t          data_q  [DEPTH];

    logic [PTR_W-1:0] head_q;
    logic [PTR_W-1:0] tail_q;
    logic [CNT_W-1:0] count_q;

    logic [DEPTH-1:0] slot_kill;
    logic             in_kill;
    logic             not_empty;
    logic             head_live;
    logic             enq;
    logic             deq;

    always_comb begin
        slot_kill = '0;
        for (int i = 0; i < DEPTH; i++) begin
            slot_kill[i] = bus.flush_valid & younger(robid_q[i], bus.flush_robid);
        end
    end

    assign in_kill   = bus.flush_valid & younger(bus.memwb_robid, bus.flush_robid);
    assign not_empty = (count_q != '0);
    assign head_live = not_empty & vld_q[head_q] & ~slot_kill[head_q];

    // Dead heads (squashed holes) retire without waiting for the writeback port.
    assign deq = (head_live & bus.wb_ready) | (not_empty & ~head_live);
    assign enq = bus.memwb_instr_valid & ~in_kill & ((count_q != CNT_FULL) | deq);

    // Rising at DEPTH-1 leaves room for the result already sitting in MEM->WB.
    assign bus.mem_stall     = (count_q >= CNT_STALL);
    assign bus.wb_valid      = head_live;
    assign bus.wb_robid      = robid_q[head_q];
    assign bus.wb_prd        = prd_q[head_q];
    assign bus.wb_need_to_wb = need_q[head_q];
    assign bus.wb_mmio_valid = mmio_q[head_q];
    assign bus.wb_rddata     = data_q[head_q];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            vld_q   <= '0;
            need_q  <= '0;
            mmio_q  <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                robid_q[i] <= '0;
                prd_q[i]   <= '0;
                data_q[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (slot_kill[i]) begin
                    vld_q[i] <= 1'b0;
                end
            end
            if (deq) begin
                vld_q[head_q] <= 1'b0;
                head_q        <= head_q + PTR_W'(1);
            end
            // Written last so a full-buffer enqueue wins over the head slot it replaces.
            if (enq) begin
                vld_q[tail_q]   <= 1'b1;
                robid_q[tail_q] <= bus.memwb_robid;
                prd_q[tail_q]   <= bus.memwb_prd;
                need_q[tail_q]  <= bus.memwb_need_to_wb;
                mmio_q[tail_q]  <= bus.memwb_mmio_valid;
                data_q[tail_q]  <= bus.memwb_opload_rddata;
                tail_q          <= tail_q + PTR_W'(1);
            end
            case ({enq, deq})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    overflow_check: assert property (@(posedge clock) disable iff (!reset_n)
        !(bus.memwb_instr_valid && !in_kill && (count_q == CNT_FULL) && !deq));

    underflow_check: assert property (@(posedge clock) disable iff (!reset_n)
        !(deq && !not_empty));

endmodule

// File: tb/tb_load_wb_buffer.sv
// tb/tb_load_wb_buffer.sv - directed vector bench for load_wb_buffer
module tb_load_wb_buffer;
    import load_wb_buffer_pkg::*;

    typedef struct {
        logic   in_v;
        robid_t in_id;
        logic   fl_v;
        robid_t fl_id;
        logic   rdy;
        logic   exp_v;
        robid_t exp_id;
        logic   exp_stall;
    } vec_t;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;
    vec_t vecs[$];

    load_wb_buffer_if bus();

    load_wb_buffer #(.DEPTH(4), .ID_W(INSTR_ID_WIDTH)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    function automatic preg_t prd_of(input robid_t id);
        return preg_t'(id + 6'd7);
    endfunction

    function automatic result_t data_of(input robid_t id);
        return {32'(id) ^ 32'h5, 32'hDEAD_BEEF ^ 32'(id) ^ 32'h5};
    endfunction

    function automatic vec_t mk(input logic iv, input int iid, input logic fv, input int fid,
                                input logic rdy, input logic ev, input int eid, input logic est);
        vec_t v;
        v.in_v = iv;   v.in_id = robid_t'(iid);
        v.fl_v = fv;   v.fl_id = robid_t'(fid);
        v.rdy = rdy;   v.exp_v = ev;
        v.exp_id = robid_t'(eid);
        v.exp_stall = est;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        bus.memwb_instr_valid   = v.in_v;
        bus.memwb_robid         = v.in_v ? v.in_id : '0;
        bus.memwb_prd           = v.in_v ? prd_of(v.in_id) : '0;
        bus.memwb_need_to_wb    = v.in_v & v.in_id[1];
        bus.memwb_mmio_valid    = v.in_v & v.in_id[2];
        bus.memwb_opload_rddata = v.in_v ? data_of(v.in_id) : '0;
        bus.flush_valid         = v.fl_v;
        bus.flush_robid         = v.fl_id;
        bus.wb_ready            = v.rdy;
    endtask

    task automatic check_vec(input string tag, input vec_t v);
        check({tag, " wb_valid"}, 64'(bus.wb_valid), 64'(v.exp_v));
        check({tag, " mem_stall"}, 64'(bus.mem_stall), 64'(v.exp_stall));
        if (v.exp_v) begin
            check({tag, " wb_robid"}, 64'(bus.wb_robid), 64'(v.exp_id));
            check({tag, " wb_prd"}, 64'(bus.wb_prd), 64'(prd_of(v.exp_id)));
            check({tag, " wb_need_to_wb"}, 64'(bus.wb_need_to_wb), 64'(v.exp_id[1]));
            check({tag, " wb_mmio_valid"}, 64'(bus.wb_mmio_valid), 64'(v.exp_id[2]));
            check({tag, " wb_rddata"}, bus.wb_rddata, data_of(v.exp_id));
        end
    endtask

    initial begin
        vec_t idle;
        idle = mk(0, 0, 0, 0, 1, 0, 0, 0);

        // pass-through: robid 5, prd 12, data 0xDEADBEEF
        vecs.push_back(mk(1, 5, 0, 0, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 1, 5, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0));
        // backpressure: 1,2,3 then in-flight 4, then drain in order
        vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 2, 0, 0, 0, 1, 1, 0));
        vecs.push_back(mk(1, 3, 0, 0, 0, 1, 1, 0));
        vecs.push_back(mk(1, 4, 0, 0, 0, 1, 1, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 1, 1));
        vecs.push_back(mk(0, 0, 0, 0, 1, 1, 1, 1));
        vecs.push_back(mk(0, 0, 0, 0, 1, 1, 2, 1));
        vecs.push_back(mk(0, 0, 0, 0, 1, 1, 3, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 1, 4, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0));
        // full buffer with simultaneous enqueue and dequeue
        vecs.push_back(mk(1, 10, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 11, 0, 0, 0, 1, 10, 0));
        vecs.push_back(mk(1, 12, 0, 0, 0, 1, 10, 0));
        vecs.push_back(mk(1, 13, 0, 0, 0, 1, 10, 1));
        vecs.push_back(mk(1, 14, 0, 0, 1, 1, 10, 1));
        vecs.push_back(mk(0, 0, 0, 0, 1, 1, 11, 1));
        vecs.push_back(mk(0, 0, 0, 0, 1, 1, 12, 1));
        vecs.push_back(mk(0, 0, 0, 0, 1, 1, 13, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 1, 14, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0));
        // flush 5 with 3,7,9 held and 8 arriving
        vecs.push_back(mk(1, 3, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 7, 0, 0, 0, 1, 3, 0));
        vecs.push_back(mk(1, 9, 0, 0, 0, 1, 3, 0));
        vecs.push_back(mk(1, 8, 1, 5, 1, 1, 3, 1));
        vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0));
        vecs.push_back(mk(1, 20, 0, 0, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 1, 20, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0));
        // wrap compare: flush {1,2} against {0,30},{1,1},{1,3}
        vecs.push_back(mk(1, 30, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 33, 0, 0, 0, 1, 30, 0));
        vecs.push_back(mk(1, 35, 0, 0, 0, 1, 30, 0));
        vecs.push_back(mk(0, 0, 1, 34, 0, 1, 30, 1));
        vecs.push_back(mk(0, 0, 0, 0, 1, 1, 30, 1));
        vecs.push_back(mk(0, 0, 0, 0, 1, 1, 33, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0));
        // killed head is hidden the same cycle; robid equal to flush id survives
        vecs.push_back(mk(1, 40, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 38, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0));
        vecs.push_back(mk(1, 50, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 50, 1, 1, 50, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0));

        drive(idle);
        @(negedge clock);
        #1;
        check("reset wb_valid", 64'(bus.wb_valid), 64'd0);
        check("reset mem_stall", 64'(bus.mem_stall), 64'd0);
        check("reset wb_robid", 64'(bus.wb_robid), 64'd0);
        check("reset wb_rddata", bus.wb_rddata, 64'd0);
        @(negedge clock);
        reset_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clock);
            drive(vecs[i]);
            #1;
            check_vec($sformatf("vec%0d", i), vecs[i]);
        end

        // asynchronous reset while three entries are held
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            drive(mk(1, 60 + i, 0, 0, 0, 0, 0, 0));
        end
        @(negedge clock);
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0));
        #1;
        check("pre-reset wb_valid", 64'(bus.wb_valid), 64'd1);
        check("pre-reset mem_stall", 64'(bus.mem_stall), 64'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("midreset wb_valid", 64'(bus.wb_valid), 64'd0);
        check("midreset mem_stall", 64'(bus.mem_stall), 64'd0);
        check("midreset wb_robid", 64'(bus.wb_robid), 64'd0);
        check("midreset wb_rddata", bus.wb_rddata, 64'd0);
        @(negedge clock);
        reset_n = 1'b1;
        drive(idle);
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            #1;
            check($sformatf("postreset%0d wb_valid", i), 64'(bus.wb_valid), 64'd0);
            check($sformatf("postreset%0d mem_stall", i), 64'(bus.mem_stall), 64'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
